// File: rtl/memctl.sv
// memctl: sequences single load/store accesses to a data memory whose read data is
// registered (one cycle read latency).
//
// Ports
//   clk           clock, all state changes on its rising edge
//   reset_memctl  synchronous active-low reset
//   start, op     access request (op: 1 = store, 0 = load), sampled only in IDLE
//   addr, reg_val address and store data, captured when a request is accepted
//   dmem_data     registered read data from the data memory
//   dmem_addr     address to the data memory
//   read_val      write data to the data memory
//   REDMEM        data-memory write enable
//   load_data     captured load result for the register file
//   WEREG         register-file write strobe (one cycle, loads only)
//   busy          high while not in IDLE
//   done          one-cycle completion pulse
// Every output comes straight from a flop.
module memctl (
  input  logic       clk,
  input  logic       reset_memctl,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] addr,
  input  logic [7:0] reg_val,
  input  logic [7:0] dmem_data,
  output logic [7:0] dmem_addr,
  output logic [7:0] read_val,
  output logic       REDMEM,
  output logic [7:0] load_data,
  output logic       WEREG,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle,
    StStore,
    StLoadAddr,
    StLoadWait,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] dmem_addr_q, dmem_addr_d;
  logic [7:0] read_val_q, read_val_d;
  logic [7:0] load_data_q, load_data_d;
  logic       redmem_q, redmem_d;
  logic       wereg_q, wereg_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    dmem_addr_d = dmem_addr_q;
    read_val_d  = read_val_q;
    load_data_d = load_data_q;
    redmem_d    = 1'b0;
    wereg_d     = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dmem_addr_d = addr;
          read_val_d  = reg_val;
          redmem_d    = op;
          state_d     = op ? StStore : StLoadAddr;
        end
      end
      StStore: begin
        done_d  = 1'b1;
        state_d = StDone;
      end
      // Memory registers its read data at the end of this cycle.
      StLoadAddr: begin
        state_d = StLoadWait;
      end
      StLoadWait: begin
        load_data_d = dmem_data;
        wereg_d     = 1'b1;
        done_d      = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered busy tracks the state it will be in next cycle.
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_memctl) begin
      state_q     <= StIdle;
      dmem_addr_q <= 8'h00;
      read_val_q  <= 8'h00;
      load_data_q <= 8'h00;
      redmem_q    <= 1'b0;
      wereg_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dmem_addr_q <= dmem_addr_d;
      read_val_q  <= read_val_d;
      load_data_q <= load_data_d;
      redmem_q    <= redmem_d;
      wereg_q     <= wereg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign dmem_addr = dmem_addr_q;
  assign read_val  = read_val_q;
  assign load_data = load_data_q;
  assign REDMEM    = redmem_q;
  assign WEREG     = wereg_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_memctl.sv
// Testbench for memctl: a behavioural data memory with registered read data, a shadow copy of
// the memory contents, and a scoreboard queue of expected load results.
module tb_memctl;

  logic       clk = 1'b0;
  logic       reset_memctl;
  logic       start;
  logic       op;
  logic [7:0] addr;
  logic [7:0] reg_val;
  logic [7:0] dmem_data;
  logic [7:0] dmem_addr;
  logic [7:0] read_val;
  logic       REDMEM;
  logic [7:0] load_data;
  logic       WEREG;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  memctl dut (
    .clk         (clk),
    .reset_memctl(reset_memctl),
    .start       (start),
    .op          (op),
    .addr        (addr),
    .reg_val     (reg_val),
    .dmem_data   (dmem_data),
    .dmem_addr   (dmem_addr),
    .read_val    (read_val),
    .REDMEM      (REDMEM),
    .load_data   (load_data),
    .WEREG       (WEREG),
    .busy        (busy),
    .done        (done)
  );

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (REDMEM) mem[dmem_addr] <= read_val;
    dmem_data <= mem[dmem_addr];
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] shadow [256];
  logic [7:0] sb_q [$];
  logic [7:0] exp_load = 8'h00;
  logic [7:0] exp_addr = 8'h00;

  task automatic test_reset();
    reset_memctl = 1'b0;
    start = 1'b0; op = 1'b0; addr = 8'h00; reg_val = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({dmem_addr, read_val, load_data, REDMEM, WEREG, done} !== 27'd0) begin
      bad++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h ld=%h we=%b wereg=%b done=%b, want all 0",
               dmem_addr, read_val, load_data, REDMEM, WEREG, done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset_memctl = 1'b1;
    exp_load = 8'h00;
    exp_addr = 8'h00;
  endtask

  task automatic test_store(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    start = 1'b1; op = 1'b1; addr = a; reg_val = v;
    shadow[a] = v;
    exp_addr = a;
    @(negedge clk);
    // Changing inputs after acceptance must not disturb the access.
    start = 1'b0; addr = ~a; reg_val = ~v;
    total++;
    if (REDMEM !== 1'b1 || dmem_addr !== a || read_val !== v || busy !== 1'b1) begin
      bad++;
      $display("FAIL store_issue: got we=%b addr=%h wdata=%h busy=%b, want 1 %h %h 1",
               REDMEM, dmem_addr, read_val, busy, a, v);
    end
    total++;
    if (WEREG !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL store_early: got wereg=%b done=%b, want 0 0", WEREG, done);
    end
    @(negedge clk);
    total++;
    if (REDMEM !== 1'b0 || done !== 1'b1 || WEREG !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL store_done: got we=%b done=%b wereg=%b busy=%b, want 0 1 0 1",
               REDMEM, done, WEREG, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || REDMEM !== 1'b0 || WEREG !== 1'b0) begin
      bad++;
      $display("FAIL store_idle: got done=%b busy=%b we=%b wereg=%b, want 0 0 0 0",
               done, busy, REDMEM, WEREG);
    end
    total++;
    if (load_data !== exp_load) begin
      bad++;
      $display("FAIL store_ld_hold: got %h want %h", load_data, exp_load);
    end
  endtask

  // poke=1 drives start (as a store to 8'h10) while the load sits in LOAD_WAIT and DONE.
  task automatic test_load(input logic [7:0] a, input bit poke);
    int         wereg_cyc;
    int         wereg_cnt;
    int         busy_cnt;
    logic [7:0] exp;
    wereg_cyc = 0; wereg_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; addr = a; reg_val = 8'h00;
    sb_q.push_back(shadow[a]);
    exp_addr = a;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      total++;
      if (REDMEM !== 1'b0) begin
        bad++;
        $display("FAIL load_we: cycle %0d got REDMEM=%b want 0", c, REDMEM);
      end
      total++;
      if (dmem_addr !== a) begin
        bad++;
        $display("FAIL load_addr: cycle %0d got %h want %h", c, dmem_addr, a);
      end
      if (WEREG === 1'b1) begin
        wereg_cnt++;
        wereg_cyc = c;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
        exp_load = exp;
        total++;
        if (load_data !== exp || done !== 1'b1) begin
          bad++;
          $display("FAIL load_result: got data=%h done=%b want %h 1", load_data, done, exp);
        end
      end else begin
        total++;
        if (done !== 1'b0) begin
          bad++;
          $display("FAIL load_done_alone: cycle %0d got done=1 without WEREG", c);
        end
      end
      if (poke && (c == 2 || c == 3)) begin
        start = 1'b1; op = 1'b1; addr = 8'h10; reg_val = 8'hEE;
      end else begin
        start = 1'b0; addr = ~a; reg_val = 8'h33;
      end
    end
    total++;
    if (wereg_cnt != 1 || wereg_cyc != 3) begin
      bad++;
      $display("FAIL load_latency: got %0d strobes at cycle %0d, want 1 at cycle 3",
               wereg_cnt, wereg_cyc);
    end
    total++;
    if (busy_cnt != 3) begin
      bad++;
      $display("FAIL load_busy: got %0d busy cycles want 3", busy_cnt);
    end
    total++;
    if (load_data !== exp_load) begin
      bad++;
      $display("FAIL load_hold: got %h want %h", load_data, exp_load);
    end
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0; op = 1'b1; addr = 8'h80 + 8'(c); reg_val = 8'h11;
      total++;
      if (dmem_addr !== exp_addr || REDMEM !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold: got addr=%h we=%b busy=%b want %h 0 0",
                 dmem_addr, REDMEM, busy, exp_addr);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; op = 1'b0; addr = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // Now in LOAD_WAIT.
    reset_memctl = 1'b0;
    @(negedge clk);
    exp_load = 8'h00;
    total++;
    if (busy !== 1'b0 || load_data !== 8'h00 || WEREG !== 1'b0 || done !== 1'b0 ||
        dmem_addr !== 8'h00) begin
      bad++;
      $display("FAIL midreset_abort: got busy=%b ld=%h wereg=%b done=%b addr=%h, want all 0",
               busy, load_data, WEREG, done, dmem_addr);
    end
    // Request on the very edge after release.
    reset_memctl = 1'b1;
    start = 1'b1; op = 1'b1; addr = 8'h44; reg_val = 8'h99;
    shadow[8'h44] = 8'h99;
    exp_addr = 8'h44;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || REDMEM !== 1'b1 || dmem_addr !== 8'h44 || WEREG !== 1'b0 ||
        done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_restart: got busy=%b we=%b addr=%h wereg=%b done=%b, want 1 1 44 0 0",
               busy, REDMEM, dmem_addr, WEREG, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || WEREG !== 1'b0) begin
      bad++;
      $display("FAIL midreset_store_done: got done=%b wereg=%b want 1 0", done, WEREG);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] v;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      v = 8'($urandom_range(0, 255));
      test_store(a, v);
      test_load(a, 1'b0);
    end
    test_load(8'h44, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store(8'h3C, 8'hA5);
    test_load(8'h3C, 1'b0);
    test_load(8'h3C, 1'b1);
    test_idle_hold();
    test_mid_reset();
    test_store(8'hFF, 8'h5A);
    test_load(8'hFF, 1'b0);
    test_back_to_back();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memctl.md
MEMCTL -- requirements
Module: memctl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_memctl, input, 1 bit: reset is synchronous and active-low, and is sampled only on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit: memory-access request from the control unit, sampled only in IDLE.
REQ-004 SHALL have port op, input, 1 bit: 1 = store, 0 = load, sampled together with start.
REQ-005 SHALL have port addr, input, 8 bits: data-memory address taken from the IR.
REQ-006 SHALL have port reg_val, input, 8 bits: store data from register R.
REQ-007 SHALL have port dmem_data, input, 8 bits: registered read data returned by the data memory.
REQ-008 SHALL have port dmem_addr, output, 8 bits: address to the data memory.
REQ-009 SHALL have port read_val, output, 8 bits: write data to the data memory.
REQ-010 SHALL have port REDMEM, output, 1 bit: data-memory write enable, active high.
REQ-011 SHALL have port load_data, output, 8 bits: captured load result for the register file.
REQ-012 SHALL have port WEREG, output, 1 bit: register-file write strobe, 1 cycle wide.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: completion pulse, 1 cycle wide.
REQ-015 SHALL drive every output from a register; no combinational input-to-output paths.

Function
REQ-016 SHALL implement the states IDLE, STORE, LOAD_ADDR, LOAD_WAIT and DONE.
REQ-017 In IDLE with start=1 at edge E0, SHALL latch dmem_addr<=addr and read_val<=reg_val, set REDMEM<=op, and go to STORE if op=1 or LOAD_ADDR if op=0.
REQ-018 In IDLE with start=0, SHALL hold dmem_addr and read_val, keep REDMEM=0, and stay in IDLE.
REQ-019 STORE: REDMEM=1 for exactly one cycle (E0 to E1); at E1 SHALL set REDMEM<=0, done<=1, and go to DONE. Store latency: done is high in the cycle after E1.
REQ-020 LOAD_ADDR: REDMEM=0 and dmem_addr stable; at E1 SHALL go to LOAD_WAIT, because the memory registers its read data at E1.
REQ-021 LOAD_WAIT: at E2 SHALL set load_data<=dmem_data, WEREG<=1, done<=1, and go to DONE. Load latency: WEREG and done are high in the cycle after E2.
REQ-022 DONE: at the next edge SHALL clear done and WEREG and go to IDLE; load_data SHALL hold its value until the next load completes.
REQ-023 start SHALL be ignored in every state other than IDLE, including DONE, so back-to-back requests are spaced by at least one IDLE cycle.
REQ-024 addr and reg_val changes after E0 SHALL NOT affect the access in flight.
REQ-025 REDMEM SHALL never be high in any state other than STORE.
REQ-026 WEREG SHALL never be asserted for a store.
REQ-027 The 8-bit address SHALL cover 0 to 255 with no wrap or range check; address 8'hFF SHALL be handled like any other address.

Reset
REQ-028 With reset_memctl=0 at an edge, SHALL go to IDLE and clear dmem_addr, read_val, load_data, REDMEM, WEREG, busy and done to 0; reset SHALL take priority over every transition.
REQ-029 Reset asserted mid-operation SHALL abort the access with no done or WEREG pulse.
REQ-030 A store aborted by reset at E1 still completes its memory write, because the memory samples REDMEM=1 at E1; this is accepted behaviour.
REQ-031 After reset is released, SHALL accept start at the first following edge.

Verification
REQ-032 Reset: hold reset_memctl=0 for 2 cycles -> all outputs 0, busy=0.
REQ-033 Store: start=1, op=1, addr=8'h3C, reg_val=8'hA5 -> REDMEM=1 for 1 cycle with dmem_addr=8'h3C and read_val=8'hA5; done 1 cycle later; WEREG stays 0.
REQ-034 Load after store: start=1, op=0, addr=8'h3C -> load_data=8'hA5 with WEREG=1 and done=1 in the same cycle, 2 edges after acceptance; busy high for 3 cycles total.
REQ-035 Ignored start: pulse start during LOAD_WAIT and during DONE with addr=8'h10 -> no new access, dmem_addr stays 8'h3C.
REQ-036 Mid-operation reset: assert reset during LOAD_WAIT -> next cycle IDLE, load_data=0, no WEREG or done pulse.
REQ-037 Boundary address: store 8'h5A to addr=8'hFF, then load from 8'hFF -> load_data=8'h5A.
